// File: rtl/uart_pkg.sv
// Shared constants and types for the framed UART transmitter.
package uart_pkg;

  // Each bit time is this many prescale ticks.
  localparam int unsigned OVERSAMPLE = 8;

  // Parity mode encoding on cfg_parity; values 5..7 behave as none.
  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // True when the mode inserts a parity bit into the frame.
  function automatic logic parity_enabled(input logic [2:0] mode);
    logic en;
    case (mode)
      PAR_NONE:                                 en = 1'b0;
      PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE:   en = 1'b1;
      default:                                  en = 1'b0;
    endcase
    return en;
  endfunction

  // Parity bit value given the XOR of the data bits actually sent.
  function automatic logic parity_value(input logic [2:0] mode, input logic data_xor);
    logic p;
    case (mode)
      PAR_EVEN:  p = data_xor;
      PAR_ODD:   p = ~data_xor;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: registered storage, combinational head read, occupancy count.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;

  // Pointer and count update; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: AXI-stream input FIFO feeding a configurable serializer.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, waiting for a queued word
// ST_START  | start bit (low) for one bit time
// ST_DATA   | data bits LSB first, count latched at frame start
// ST_PARITY | optional parity bit
// ST_STOP   | one or two stop bits (high)
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count,
  input  logic [15:0]           prescale,
  input  logic [3:0]            cfg_data_bits,
  input  logic [2:0]            cfg_parity,
  input  logic                  cfg_stop2
);

  // Bit timer wide enough for 8 * 65535 cycles.
  localparam int TW = 19;
  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic                  load;

  tx_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         reload_q, reload_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  stop2_q, stop2_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  txd_q, txd_d;

  logic [3:0]            nbits_in;
  logic                  word_xor;
  logic [15:0]           pscale_eff;
  logic [TW-1:0]         reload_in;
  logic                  tc;

  assign s_axis_tready = ~fifo_full & ~rst;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_axis_tvalid & s_axis_tready),
    .wr_data (s_axis_tdata),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Frame parameters as they would be latched from the live inputs and FIFO head.
  always_comb begin
    if (cfg_data_bits < 4'd5)          nbits_in = 4'd5;
    else if (cfg_data_bits > MAX_BITS) nbits_in = MAX_BITS;
    else                               nbits_in = cfg_data_bits;
    word_xor = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) < nbits_in) word_xor = word_xor ^ fifo_rd_data[i];
    end
    pscale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    reload_in  = TW'(pscale_eff) * TW'(OVERSAMPLE) - TW'(1);
  end

  assign tc = (timer_q == '0);

  // Next-state and datapath: bit timer counts down, advancing on terminal count.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    shreg_d    = shreg_q;
    nbits_d    = nbits_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    load       = 1'b0;

    if (state_q != ST_IDLE && !tc) timer_d = timer_q - TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (tc) begin
          state_d   = ST_DATA;
          timer_d   = reload_q;
          bit_cnt_d = nbits_q - 4'd1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          timer_d = reload_q;
          if (bit_cnt_q == 4'd0) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = stop2_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tc) begin
          state_d    = ST_STOP;
          timer_d    = reload_q;
          stop_cnt_d = stop2_q;
        end
      end
      ST_STOP: begin
        if (tc) begin
          if (stop_cnt_q) begin
            stop_cnt_d = 1'b0;
            timer_d    = reload_q;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starting a frame snapshots word and configuration so later input changes wait a frame.
    if (load) begin
      state_d   = ST_START;
      shreg_d   = fifo_rd_data;
      nbits_d   = nbits_in;
      stop2_d   = cfg_stop2;
      par_en_d  = parity_enabled(cfg_parity);
      par_bit_d = parity_value(cfg_parity, word_xor);
      reload_d  = reload_in;
      timer_d   = reload_in;
    end
  end

  // Line level for the upcoming bit, registered so txd changes on the state edge.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_bit_d;
      default:   txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      reload_q   <= '0;
      shreg_q    <= '0;
      nbits_q    <= 4'd0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      reload_q   <= reload_d;
      shreg_q    <= shreg_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      txd_q      <= txd_d;
    end
  end

  // Outputs are forced to their reset values for as long as rst is held.
  assign txd        = txd_q | rst;
  assign busy       = ~rst & ((state_q != ST_IDLE) | (fifo_cnt != '0));
  assign fifo_count = rst ? '0 : fifo_cnt;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed with hand-computed frame patterns.
module tb_uart_tx_framed;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          txd;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [15:0]   prescale = 16'd1;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic [2:0]    cfg_parity = 3'd0;
  logic          cfg_stop2 = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_tx_framed #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .prescale      (prescale),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents a word and waits (bounded) for the handshake edge; leaves tvalid high.
  task automatic push(input logic [DW-1:0] w);
    int  t;
    logic acc;
    t = 0;
    acc = 1'b0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    while (!acc && t < 50) begin
      acc = s_axis_tready;
      tick();
      t++;
    end
    check_eq("push_accept", acc, 1);
  endtask

  // Waits for a start bit, then compares every cycle of the frame against exp (bit i = i-th sent).
  task automatic frame_chk(input string tag, input int nbits, input logic [15:0] exp, input int bt);
    int t;
    int nerr;
    logic [15:0] obs;
    t = 0;
    while (txd !== 1'b0 && t < 2000) begin
      tick();
      t++;
    end
    check_eq({tag, "_start"}, txd, 0);
    obs = '0;
    nerr = 0;
    for (int j = 0; j < nbits * bt; j++) begin
      if (txd !== exp[j / bt]) nerr++;
      if (j % bt == bt / 2) obs[j / bt] = txd;
      tick();
    end
    check_eq({tag, "_bits"}, obs, exp);
    check_eq({tag, "_timing"}, nerr, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] words [6];
    int idx, start_cyc, end_cyc, t;
    logic acc;

    // Reset state
    repeat (3) tick();
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_count", fifo_count, 0);
    rst = 1'b0;
    #1;
    check_eq("tready_after_rst", s_axis_tready, 1);
    tick();

    // 8N1, prescale 1, 0xA5; start bit on the edge after acceptance
    push(8'hA5);
    s_axis_tvalid = 1'b0;
    check_eq("a5_idle_at_accept", txd, 1);
    check_eq("a5_count_at_accept", fifo_count, 1);
    tick();
    check_eq("a5_start_next_edge", txd, 0);
    frame_chk("8n1_a5", 10, 16'b1101001010, 8);
    check_eq("a5_idle_after", txd, 1);
    check_eq("a5_busy_after", busy, 0);

    // 7E2 and 7O2, prescale 2; bit 7 of 0xC1 lies above the data count
    prescale = 16'd2; cfg_data_bits = 4'd7; cfg_parity = 3'd1; cfg_stop2 = 1'b1;
    push(8'h41);
    s_axis_tvalid = 1'b0;
    frame_chk("7e2_41", 11, 16'b11010000010, 16);
    cfg_parity = 3'd2;
    push(8'hC1);
    s_axis_tvalid = 1'b0;
    frame_chk("7o2_c1", 11, 16'b11110000010, 16);

    // Data count below 5 clamps to 5; parity code 5 acts as none
    prescale = 16'd1; cfg_data_bits = 4'd2; cfg_parity = 3'd5; cfg_stop2 = 1'b0;
    push(8'hFF);
    s_axis_tvalid = 1'b0;
    frame_chk("clamp5", 7, 16'b1111110, 8);

    // prescale 0 behaves as 1
    prescale = 16'd0; cfg_data_bits = 4'd8; cfg_parity = 3'd0;
    push(8'h3C);
    s_axis_tvalid = 1'b0;
    frame_chk("psc0_3c", 10, 16'b1001111000, 8);

    // Parity switched to even mid-frame applies only to the following frame
    prescale = 16'd1;
    push(8'h55);
    push(8'h0F);
    s_axis_tvalid = 1'b0;
    cfg_parity = 3'd1;
    frame_chk("midcfg_f1", 10, 16'b1010101010, 8);
    check_eq("midcfg_no_gap", txd, 0);
    frame_chk("midcfg_f2", 11, 16'b10000011110, 8);
    check_eq("midcfg_busy_end", busy, 0);
    cfg_parity = 3'd0;

    // FIFO full with tvalid held; five frames back to back at 800 cycles per bit
    prescale = 16'd100;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    words[3] = 8'h04; words[4] = 8'h05; words[5] = 8'h06;
    idx = 0;
    start_cyc = -1;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_axis_tdata = words[idx];
      acc = s_axis_tready;
      tick();
      if (acc && idx < 5) idx++;
      if (txd == 1'b0 && start_cyc < 0) start_cyc = cyc;
    end
    s_axis_tvalid = 1'b0;
    check_eq("b2b_accepted", idx, 5);
    check_eq("b2b_tready_full", s_axis_tready, 0);
    check_eq("b2b_count", fifo_count, 4);
    check_eq("b2b_busy", busy, 1);
    t = 0;
    while (busy && t < 60000) begin
      tick();
      t++;
    end
    end_cyc = cyc;
    check_eq("b2b_duration", end_cyc - start_cyc, 40000);

    // Reset while in DATA with three words queued
    prescale = 16'd1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    s_axis_tvalid = 1'b0;
    repeat (10) tick();
    check_eq("prerst_count", fifo_count, 3);
    rst = 1'b1;
    tick();
    check_eq("midrst_txd", txd, 1);
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_tready", s_axis_tready, 0);
    rst = 1'b0;
    tick();
    check_eq("postrst_tready", s_axis_tready, 1);
    repeat (20) tick();
    check_eq("postrst_txd", txd, 1);
    check_eq("postrst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
